bias_act_unit: RTL and testbench

- Downstream neighbour of dot_prod. Consumes the NROW-wide fixed-point result vector when dot_prod raises dataReady.
- Adds a per-row bias with saturation, then applies a piecewise-linear activation to each row: hard sigmoid for gates, hard tanh for candidate/cell.
- Processes LANES rows per clock, so DSP/LUT use scales with LANES rather than NROW.
- Presents a registered activated vector with a one-cycle outReady strobe to the LSTM cell-update stage.

---
 rtl/bias_act_unit.sv | 166 ++++++++++++++++
 tb/tb_bias_act_unit.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bias_act_unit.sv
// ============================================================================
// Module   : bias_act_unit
// Brief    : Per-row saturating bias add followed by hard sigmoid / hard tanh,
//            LANES rows per clock, with a one-cycle outReady completion strobe.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bias_act_unit #(
    parameter int NROW  = 16,
    parameter int QN    = 6,
    parameter int QM    = 11,
    parameter int LANES = 4,
    localparam int BITWIDTH     = QN + QM + 1,
    localparam int VEC_BITWIDTH = BITWIDTH * NROW
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    dataReady,
    input  logic [VEC_BITWIDTH-1:0] inputVec,
    input  logic [VEC_BITWIDTH-1:0] biasVec,
    input  logic                    actSel,
    output logic [VEC_BITWIDTH-1:0] outputVec,
    output logic                    outReady,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IDX_W = $clog2(NROW) + 1;

    localparam logic signed [BITWIDTH:0]   SAT_HI  = (BITWIDTH+1)'((2**(BITWIDTH-1)) - 1);
    localparam logic signed [BITWIDTH:0]   SAT_LO  = (BITWIDTH+1)'(-(2**(BITWIDTH-1)));
    localparam logic signed [BITWIDTH:0]   ONE_W   = (BITWIDTH+1)'(2**QM);
    localparam logic signed [BITWIDTH:0]   HALF_W  = (BITWIDTH+1)'(2**(QM-1));
    localparam logic signed [BITWIDTH-1:0] ONE     = BITWIDTH'(2**QM);
    localparam logic signed [BITWIDTH-1:0] NEG_ONE = BITWIDTH'(-(2**QM));

    generate
        if (NROW % LANES != 0) begin : g_cfg_check
            $error("bias_act_unit: NROW must be a multiple of LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic [VEC_BITWIDTH-1:0]   in_vec_q, in_vec_d;
    logic [VEC_BITWIDTH-1:0]   bias_vec_q, bias_vec_d;
    logic                      act_sel_q, act_sel_d;
    logic [VEC_BITWIDTH-1:0]   output_vec_q, output_vec_d;
    logic                      out_ready_q, out_ready_d;
    logic                      busy_q, busy_d;
    logic                      overrun_q, overrun_d;
    logic                      data_ready_q;
    logic                      data_ready_rise;

    // Saturate the 19-bit sum back to the element range, then apply the
    // selected activation; the sigmoid offset is added before clamping.
    function automatic logic signed [BITWIDTH-1:0] act_row(
        input logic signed [BITWIDTH-1:0] x,
        input logic signed [BITWIDTH-1:0] b,
        input logic                       tanh_sel
    );
        logic signed [BITWIDTH:0]   sum;
        logic signed [BITWIDTH:0]   t;
        logic signed [BITWIDTH-1:0] s;
        logic signed [BITWIDTH-1:0] y;
        sum = $signed({x[BITWIDTH-1], x}) + $signed({b[BITWIDTH-1], b});
        if (sum > SAT_HI)      s = SAT_HI[BITWIDTH-1:0];
        else if (sum < SAT_LO) s = SAT_LO[BITWIDTH-1:0];
        else                   s = sum[BITWIDTH-1:0];
        t = '0;
        if (tanh_sel) begin
            if (s > ONE)          y = ONE;
            else if (s < NEG_ONE) y = NEG_ONE;
            else                  y = s;
        end else begin
            t = ($signed({s[BITWIDTH-1], s}) >>> 2) + HALF_W;
            if (t[BITWIDTH])    y = '0;
            else if (t > ONE_W) y = ONE;
            else                y = t[BITWIDTH-1:0];
        end
        return y;
    endfunction

    assign data_ready_rise = dataReady & ~data_ready_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        in_vec_d     = in_vec_q;
        bias_vec_d   = bias_vec_q;
        act_sel_d    = act_sel_q;
        output_vec_d = output_vec_q;
        out_ready_d  = 1'b0;
        overrun_d    = overrun_q | (data_ready_rise & (state_q != S_IDLE));
        case (state_q)
            S_IDLE: begin
                if (data_ready_rise) begin
                    in_vec_d   = inputVec;
                    bias_vec_d = biasVec;
                    act_sel_d  = actSel;
                    idx_d      = '0;
                    state_d    = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    output_vec_d[(int'(idx_q) + l) * BITWIDTH +: BITWIDTH] =
                        act_row(in_vec_q[(int'(idx_q) + l) * BITWIDTH +: BITWIDTH],
                                bias_vec_q[(int'(idx_q) + l) * BITWIDTH +: BITWIDTH],
                                act_sel_q);
                end
                idx_d = idx_q + IDX_W'(LANES);
                if (idx_q + IDX_W'(LANES) == IDX_W'(NROW)) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_ready_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            idx_q        <= '0;
            in_vec_q     <= '0;
            bias_vec_q   <= '0;
            act_sel_q    <= 1'b0;
            output_vec_q <= '0;
            out_ready_q  <= 1'b0;
            busy_q       <= 1'b0;
            overrun_q    <= 1'b0;
            data_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            in_vec_q     <= in_vec_d;
            bias_vec_q   <= bias_vec_d;
            act_sel_q    <= act_sel_d;
            output_vec_q <= output_vec_d;
            out_ready_q  <= out_ready_d;
            busy_q       <= busy_d;
            overrun_q    <= overrun_d;
            data_ready_q <= dataReady;
        end
    end

    assign outputVec = output_vec_q;
    assign outReady  = out_ready_q;
    assign busy      = busy_q;
    assign overrun   = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_bias_act_unit.sv
// ============================================================================
// Module   : tb_bias_act_unit
// Brief    : Directed self-checking bench for bias_act_unit (16 rows, 4 lanes).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bias_act_unit;

    localparam int NROW = 16;
    localparam int BW   = 18;
    localparam int VW   = BW * NROW;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          dataReady = 1'b0;
    logic [VW-1:0] inputVec = '0;
    logic [VW-1:0] biasVec = '0;
    logic          actSel = 1'b0;
    logic [VW-1:0] outputVec;
    logic          outReady;
    logic          busy;
    logic          overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    int x_rows   [NROW];
    int b_rows   [NROW];
    int exp_rows [NROW];

    bias_act_unit dut (
        .clock     (clock),
        .reset     (reset),
        .dataReady (dataReady),
        .inputVec  (inputVec),
        .biasVec   (biasVec),
        .actSel    (actSel),
        .outputVec (outputVec),
        .outReady  (outReady),
        .busy      (busy),
        .overrun   (overrun)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic logic signed [BW-1:0] row_of(input logic [VW-1:0] v, input int j);
        return v[j*BW +: BW];
    endfunction

    task automatic set_rows(input int x_def, input int b_def, input int e_def);
        for (int j = 0; j < NROW; j++) begin
            x_rows[j]   = x_def;
            b_rows[j]   = b_def;
            exp_rows[j] = e_def;
        end
    endtask

    // Presents the row tables with a fresh dataReady edge; returns just after
    // the capture edge with the inputs scrambled so only latched data matters.
    task automatic start_vec(input logic sel);
        logic [VW-1:0] xv, bv;
        for (int j = 0; j < NROW; j++) begin
            xv[j*BW +: BW] = BW'(x_rows[j]);
            bv[j*BW +: BW] = BW'(b_rows[j]);
        end
        dataReady = 1'b0;
        tick();
        inputVec  = xv;
        biasVec   = bv;
        actSel    = sel;
        dataReady = 1'b1;
        tick();
        inputVec  = ~xv;
        biasVec   = ~bv;
        actSel    = ~sel;
    endtask

    task automatic wait_ready(output int lat, output int busy_cnt, output int pulses,
                              output logic [VW-1:0] cap);
        lat      = -1;
        busy_cnt = busy ? 1 : 0;
        pulses   = 0;
        cap      = '0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (busy) busy_cnt++;
            if (outReady) begin
                pulses++;
                if (lat < 0) begin
                    lat = k;
                    cap = outputVec;
                end
            end
        end
        dataReady = 1'b0;
    endtask

    task automatic test_reset();
        int lat, bc, pc;
        logic [VW-1:0] cap;
        reset     = 1'b1;
        dataReady = 1'b1;
        actSel    = 1'b1;
        for (int i = 0; i < VW/32; i++) begin
            inputVec[i*32 +: 32] = $urandom();
            biasVec[i*32 +: 32]  = $urandom();
        end
        repeat (3) tick();
        n_cmp++;
        if (outputVec !== '0) begin n_fail++; $display("FAIL reset_outputVec: got %h want 0", outputVec); end
        n_cmp++;
        if (outReady !== 1'b0) begin n_fail++; $display("FAIL reset_outReady: got %b want 0", outReady); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        reset = 1'b0;
        tick();
        n_cmp++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_release_capture: busy got %b want 1", busy); end
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL reset_release_latency: got %0d want 5", lat); end
        tick();
    endtask

    task automatic test_sigmoid();
        int lat, bc, pc;
        logic [VW-1:0] cap;
        set_rows(0, 0, 1024);
        x_rows[0] = 0;     exp_rows[0] = 1024;
        x_rows[1] = 4096;  exp_rows[1] = 2048;
        x_rows[2] = -8192; exp_rows[2] = 0;
        x_rows[3] = -3;    exp_rows[3] = 1023;
        x_rows[4] = 2048;  exp_rows[4] = 1536;
        start_vec(1'b0);
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL sigmoid_latency: got %0d want 5", lat); end
        n_cmp++;
        if (pc !== 1) begin n_fail++; $display("FAIL sigmoid_pulses: got %0d want 1", pc); end
        n_cmp++;
        if (bc !== 5) begin n_fail++; $display("FAIL sigmoid_busy_cycles: got %0d want 5", bc); end
        for (int j = 0; j < NROW; j++) begin
            n_cmp++;
            if (row_of(cap, j) !== BW'(exp_rows[j])) begin
                n_fail++;
                $display("FAIL sigmoid_row%0d: got %0d want %0d", j, row_of(cap, j), exp_rows[j]);
            end
        end
    endtask

    task automatic test_tanh();
        int lat, bc, pc;
        logic [VW-1:0] cap;
        set_rows(0, 0, 0);
        x_rows[0] = 1024;  b_rows[0] = 512;  exp_rows[0] = 1536;
        x_rows[1] = 3000;                    exp_rows[1] = 2048;
        x_rows[2] = -5000;                   exp_rows[2] = -2048;
        x_rows[3] = -100;  b_rows[3] = -200; exp_rows[3] = -300;
        start_vec(1'b1);
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL tanh_latency: got %0d want 5", lat); end
        for (int j = 0; j < NROW; j++) begin
            n_cmp++;
            if (row_of(cap, j) !== BW'(exp_rows[j])) begin
                n_fail++;
                $display("FAIL tanh_row%0d: got %0d want %0d", j, row_of(cap, j), exp_rows[j]);
            end
        end
    endtask

    task automatic test_saturation();
        int lat, bc, pc;
        logic [VW-1:0] cap;
        for (int m = 0; m < 2; m++) begin
            set_rows(0, 0, (m == 1) ? 0 : 1024);
            x_rows[0] = 131000;  b_rows[0] = 1000; exp_rows[0] = 2048;
            x_rows[1] = -131072; b_rows[1] = -1;   exp_rows[1] = (m == 1) ? -2048 : 0;
            start_vec(m == 1);
            wait_ready(lat, bc, pc, cap);
            n_cmp++;
            if (lat !== 5) begin n_fail++; $display("FAIL sat_latency_sel%0d: got %0d want 5", m, lat); end
            for (int j = 0; j < 4; j++) begin
                n_cmp++;
                if (row_of(cap, j) !== BW'(exp_rows[j])) begin
                    n_fail++;
                    $display("FAIL sat_sel%0d_row%0d: got %0d want %0d", m, j, row_of(cap, j), exp_rows[j]);
                end
            end
        end
    endtask

    task automatic test_overrun();
        int lat, bc, pc;
        logic [VW-1:0] cap;
        set_rows(0, 0, 1024);
        x_rows[1] = 4096;  exp_rows[1] = 2048;
        x_rows[2] = -8192; exp_rows[2] = 0;
        x_rows[4] = 2048;  exp_rows[4] = 1536;
        start_vec(1'b0);
        dataReady = 1'b0;
        tick();
        inputVec  = {NROW{BW'(-20000)}};
        biasVec   = '0;
        actSel    = 1'b1;
        dataReady = 1'b1;
        tick();
        n_cmp++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_set: got %b want 1", overrun); end
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 3) begin n_fail++; $display("FAIL overrun_latency: got %0d want 3", lat); end
        n_cmp++;
        if (pc !== 1) begin n_fail++; $display("FAIL overrun_pulses: got %0d want 1", pc); end
        for (int j = 0; j < 5; j++) begin
            n_cmp++;
            if (row_of(cap, j) !== BW'(exp_rows[j])) begin
                n_fail++;
                $display("FAIL overrun_row%0d: got %0d want %0d", j, row_of(cap, j), exp_rows[j]);
            end
        end
        set_rows(-5000, 0, -2048);
        x_rows[0] = 700; exp_rows[0] = 700;
        start_vec(1'b1);
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL overrun_next_latency: got %0d want 5", lat); end
        n_cmp++;
        if (row_of(cap, 0) !== BW'(700)) begin n_fail++; $display("FAIL overrun_next_row0: got %0d want 700", row_of(cap, 0)); end
        n_cmp++;
        if (row_of(cap, 15) !== BW'(-2048)) begin n_fail++; $display("FAIL overrun_next_row15: got %0d want -2048", row_of(cap, 15)); end
        n_cmp++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
    endtask

    task automatic test_reset_mid_run();
        int lat, bc, pc, stray;
        logic [VW-1:0] cap;
        set_rows(3000, 0, 2048);
        start_vec(1'b1);
        tick();
        reset     = 1'b1;
        dataReady = 1'b0;
        tick();
        reset = 1'b0;
        n_cmp++;
        if (outputVec !== '0) begin n_fail++; $display("FAIL midreset_outputVec: got %h want 0", outputVec); end
        n_cmp++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b want 0", busy); end
        n_cmp++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL midreset_overrun: got %b want 0", overrun); end
        stray = 0;
        for (int k = 0; k < 8; k++) begin
            if (outReady) stray++;
            tick();
        end
        n_cmp++;
        if (stray !== 0) begin n_fail++; $display("FAIL midreset_no_outReady: got %0d pulses want 0", stray); end
        set_rows(-3, 0, 1023);
        x_rows[7] = 2048; exp_rows[7] = 1536;
        start_vec(1'b0);
        wait_ready(lat, bc, pc, cap);
        n_cmp++;
        if (lat !== 5) begin n_fail++; $display("FAIL midreset_rerun_latency: got %0d want 5", lat); end
        for (int j = 0; j < NROW; j++) begin
            n_cmp++;
            if (row_of(cap, j) !== BW'(exp_rows[j])) begin
                n_fail++;
                $display("FAIL midreset_row%0d: got %0d want %0d", j, row_of(cap, j), exp_rows[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sigmoid();
        test_tanh();
        test_saturation();
        test_overrun();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
